// File: rtl/stereo_frame_scheduler.sv
// Frame-granular round-robin scheduler that shares one pixel sink between two camera streams,
// with power-of-two decimation, source tagging and counting of frames it has to drop.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no grant; pick the next enabled source (the one not served last)
// WAIT_SOF | grant latched in sel; waiting for its (0,0) pixel, timer running
// STREAM   | forwarding kept pixels of sel until its (H_LAST,V_LAST) pixel
module stereo_frame_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int HCOUNT_WIDTH = 10,
  parameter int VCOUNT_WIDTH = 9,
  parameter int H_LAST       = 639,
  parameter int V_LAST       = 359,
  parameter int DECIM_LOG2   = 2,
  parameter int SOF_TIMEOUT  = 2_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [1:0]              src_enable_in,
  input  logic                    src0_valid_in,
  input  logic [DATA_WIDTH-1:0]   src0_data_in,
  input  logic [HCOUNT_WIDTH-1:0] src0_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] src0_vcount_in,
  input  logic                    src1_valid_in,
  input  logic [DATA_WIDTH-1:0]   src1_data_in,
  input  logic [HCOUNT_WIDTH-1:0] src1_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] src1_vcount_in,
  input  logic                    snk_ready_in,
  output logic                    snk_valid_out,
  output logic [DATA_WIDTH-1:0]   snk_data_out,
  output logic [HCOUNT_WIDTH-1:0] snk_hcount_out,
  output logic [VCOUNT_WIDTH-1:0] snk_vcount_out,
  output logic                    snk_src_out,
  output logic                    snk_last_out,
  output logic                    frame_start_out,
  output logic                    frame_end_out,
  output logic                    busy_out,
  output logic                    overflow_out,
  output logic [15:0]             drop_count_out
);

  localparam int STEP = 1 << DECIM_LOG2;
  localparam int TW   = $clog2(SOF_TIMEOUT + 1);
  localparam logic [TW-1:0]           TIMER_LOAD = TW'(SOF_TIMEOUT - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_MASK     = HCOUNT_WIDTH'(STEP - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_MASK     = VCOUNT_WIDTH'(STEP - 1);
  localparam logic [HCOUNT_WIDTH-1:0] H_END      = HCOUNT_WIDTH'(H_LAST);
  localparam logic [VCOUNT_WIDTH-1:0] V_END      = VCOUNT_WIDTH'(V_LAST);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM} state_t;

  state_t          state;
  logic            sel;
  logic            last_src;
  logic [TW-1:0]   timer;

  logic [1:0]              sof;
  logic [1:0]              eof;
  logic [1:0]              granted;
  logic                    pix_valid;
  logic [DATA_WIDTH-1:0]   pix_data;
  logic [HCOUNT_WIDTH-1:0] pix_h;
  logic [VCOUNT_WIDTH-1:0] pix_v;
  logic [HCOUNT_WIDTH:0]   h_sum;
  logic [VCOUNT_WIDTH:0]   v_sum;
  logic                    pix_keep;
  logic                    pix_last;
  logic                    accept;
  logic                    load;
  logic                    xfer;
  logic [1:0]              drop_inc;
  logic [16:0]             drop_sum;
  logic [15:0]             drop_next;

  assign sof[0] = src0_valid_in && (src0_hcount_in == '0) && (src0_vcount_in == '0);
  assign sof[1] = src1_valid_in && (src1_hcount_in == '0) && (src1_vcount_in == '0);
  assign eof[0] = src0_valid_in && (src0_hcount_in == H_END) && (src0_vcount_in == V_END);
  assign eof[1] = src1_valid_in && (src1_hcount_in == H_END) && (src1_vcount_in == V_END);

  assign pix_valid = sel ? src1_valid_in  : src0_valid_in;
  assign pix_data  = sel ? src1_data_in   : src0_data_in;
  assign pix_h     = sel ? src1_hcount_in : src0_hcount_in;
  assign pix_v     = sel ? src1_vcount_in : src0_vcount_in;

  // Last kept pixel: no further kept column/row fits before the frame edge.
  assign pix_keep = ((pix_h & H_MASK) == '0) && ((pix_v & V_MASK) == '0);
  assign h_sum    = {1'b0, pix_h} + (HCOUNT_WIDTH + 1)'(STEP);
  assign v_sum    = {1'b0, pix_v} + (VCOUNT_WIDTH + 1)'(STEP);
  assign pix_last = (h_sum > (HCOUNT_WIDTH + 1)'(H_LAST)) && (v_sum > (VCOUNT_WIDTH + 1)'(V_LAST));

  assign granted[0] = (state != IDLE) && !sel;
  assign granted[1] = (state != IDLE) && sel;

  assign accept = (state == STREAM) || ((state == WAIT_SOF) && sof[sel]);
  assign load   = accept && pix_valid && pix_keep;
  assign xfer   = snk_valid_out && snk_ready_in;

  // Both sources can miss a grant in the same cycle, so the counter may step by two.
  assign drop_inc  = {1'b0, sof[0] && !granted[0]} + {1'b0, sof[1] && !granted[1]};
  assign drop_sum  = {1'b0, drop_count_out} + {15'b0, drop_inc};
  assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      sel             <= 1'b0;
      last_src        <= 1'b1;
      timer           <= '0;
      snk_valid_out   <= 1'b0;
      snk_data_out    <= '0;
      snk_hcount_out  <= '0;
      snk_vcount_out  <= '0;
      snk_src_out     <= 1'b0;
      snk_last_out    <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      overflow_out    <= 1'b0;
      drop_count_out  <= '0;
    end else begin
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      drop_count_out  <= drop_next;

      if (load) begin
        if (!snk_valid_out || xfer) begin
          snk_valid_out  <= 1'b1;
          snk_data_out   <= pix_data;
          snk_hcount_out <= pix_h;
          snk_vcount_out <= pix_v;
          snk_src_out    <= sel;
          snk_last_out   <= pix_last;
        end else begin
          overflow_out   <= 1'b1;
        end
      end else if (xfer) begin
        snk_valid_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (src_enable_in[~last_src]) begin
            sel   <= ~last_src;
            timer <= TIMER_LOAD;
            state <= WAIT_SOF;
          end else if (src_enable_in[last_src]) begin
            sel   <= last_src;
            timer <= TIMER_LOAD;
            state <= WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (sof[sel]) begin
            frame_start_out <= 1'b1;
            state           <= STREAM;
          end else if (timer == '0) begin
            last_src <= sel;
            state    <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STREAM: begin
          if (eof[sel]) begin
            frame_end_out <= 1'b1;
            last_src      <= sel;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Directed bench for stereo_frame_scheduler on a shrunken 16x8 frame (H_LAST=15, V_LAST=7),
// decimation by 4 (kept pixels h in {0,4,8,12}, v in {0,4}; last at (12,4)), timeout 100.
module tb_stereo_frame_scheduler;

  localparam int DW = 8;
  localparam int HW = 10;
  localparam int VW = 9;

  typedef logic [28:0] rec_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [1:0]    src_enable_in;
  logic          src0_valid_in, src1_valid_in;
  logic [DW-1:0] src0_data_in, src1_data_in;
  logic [HW-1:0] src0_hcount_in, src1_hcount_in;
  logic [VW-1:0] src0_vcount_in, src1_vcount_in;
  logic          snk_ready_in;
  logic          snk_valid_out;
  logic [DW-1:0] snk_data_out;
  logic [HW-1:0] snk_hcount_out;
  logic [VW-1:0] snk_vcount_out;
  logic          snk_src_out, snk_last_out;
  logic          frame_start_out, frame_end_out, busy_out, overflow_out;
  logic [15:0]   drop_count_out;

  int   errors = 0;
  int   checks = 0;
  rec_t q[$];
  int   fs_cnt = 0;
  int   fe_cnt = 0;

  always #5 clk_in = ~clk_in;

  stereo_frame_scheduler #(
    .DATA_WIDTH(DW), .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW),
    .H_LAST(15), .V_LAST(7), .DECIM_LOG2(2), .SOF_TIMEOUT(100)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .src_enable_in(src_enable_in),
    .src0_valid_in(src0_valid_in), .src0_data_in(src0_data_in),
    .src0_hcount_in(src0_hcount_in), .src0_vcount_in(src0_vcount_in),
    .src1_valid_in(src1_valid_in), .src1_data_in(src1_data_in),
    .src1_hcount_in(src1_hcount_in), .src1_vcount_in(src1_vcount_in),
    .snk_ready_in(snk_ready_in), .snk_valid_out(snk_valid_out), .snk_data_out(snk_data_out),
    .snk_hcount_out(snk_hcount_out), .snk_vcount_out(snk_vcount_out), .snk_src_out(snk_src_out),
    .snk_last_out(snk_last_out), .frame_start_out(frame_start_out), .frame_end_out(frame_end_out),
    .busy_out(busy_out), .overflow_out(overflow_out), .drop_count_out(drop_count_out)
  );

  // Inputs change 1 time unit after posedge, so at negedge everything is stable.
  always @(negedge clk_in) begin
    if (rst_in && snk_valid_out && snk_ready_in)
      q.push_back({snk_src_out, snk_last_out, snk_hcount_out, snk_vcount_out, snk_data_out});
    if (frame_start_out) fs_cnt++;
    if (frame_end_out) fe_cnt++;
  end

  function automatic logic [7:0] pix(input logic s, input int h, input int v);
    return {s, 4'(h), 3'(v)};
  endfunction

  function automatic rec_t exp_rec(input logic s, input int h, input int v);
    logic last;
    last = (h == 12) && (v == 4);
    return {s, last, 10'(h), 9'(v), pix(s, h, v)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input int h, input int v);
    @(posedge clk_in);
    #1;
    src0_valid_in  = m[0];
    src0_hcount_in = 10'(h);
    src0_vcount_in = 9'(v);
    src0_data_in   = pix(1'b0, h, v);
    src1_valid_in  = m[1];
    src1_hcount_in = 10'(h);
    src1_vcount_in = 9'(v);
    src1_data_in   = pix(1'b1, h, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 0, 0);
  endtask

  task automatic frame(input logic [1:0] m);
    for (int v = 0; v <= 7; v++)
      for (int h = 0; h <= 15; h++) drive(m, h, v);
  endtask

  task automatic check_frame(input int base, input logic s, input int skip_h, input string tag);
    int k;
    k = base;
    for (int v = 0; v <= 4; v += 4)
      for (int h = 0; h <= 12; h += 4) begin
        if (!(v == 0 && h == skip_h)) begin
          if (k < q.size()) chk($sformatf("%s px%0d", tag, k - base), q[k], exp_rec(s, h, v));
          k++;
        end
      end
  endtask

  task automatic do_reset(input logic [1:0] en);
    rst_in        = 1'b0;
    src_enable_in = en;
    snk_ready_in  = 1'b1;
    src0_valid_in = 1'b0;
    src1_valid_in = 1'b0;
    step(); step(); step();
    rst_in = 1'b1;
    idle(2);
  endtask

  initial begin
    int base, fs0, fe0, cnt;
    src_enable_in = 2'b00;
    snk_ready_in  = 1'b1;
    src0_valid_in = 1'b0; src0_data_in = '0; src0_hcount_in = '0; src0_vcount_in = '0;
    src1_valid_in = 1'b0; src1_data_in = '0; src1_hcount_in = '0; src1_vcount_in = '0;
    #2 rst_in = 1'b0;
    step(); step();
    chk("reset outputs", {snk_valid_out, snk_data_out, snk_hcount_out, snk_vcount_out, snk_src_out,
        snk_last_out, frame_start_out, frame_end_out, busy_out, overflow_out, drop_count_out}, 64'd0);
    rst_in = 1'b1;
    idle(3);
    chk("no enable stays idle", busy_out, 0);

    // Both enabled, simultaneous frames: grants alternate, the other frame is dropped.
    do_reset(2'b11);
    base = q.size(); fs0 = fs_cnt; fe0 = fe_cnt;
    for (int f = 0; f < 4; f++) begin
      frame(2'b11);
      idle(3);
    end
    chk("rr count", q.size() - base, 32);
    for (int f = 0; f < 4; f++) check_frame(base + 8 * f, f[0], -1, $sformatf("rr f%0d", f));
    chk("rr drops", drop_count_out, 4);
    chk("rr frame_start", fs_cnt - fs0, 4);
    chk("rr frame_end", fe_cnt - fe0, 4);

    // Only src0 enabled: every src0 frame streams, every src1 SOF is counted.
    do_reset(2'b01);
    base = q.size();
    for (int f = 0; f < 3; f++) begin
      frame(2'b11);
      idle(3);
    end
    chk("src0only count", q.size() - base, 24);
    for (int f = 0; f < 3; f++) check_frame(base + 8 * f, 1'b0, -1, $sformatf("src0only f%0d", f));
    chk("src0only drops", drop_count_out, 3);

    // Backpressure: (4,0) pending with ready low when (8,0) arrives.
    do_reset(2'b01);
    base = q.size();
    for (int v = 0; v <= 7; v++)
      for (int h = 0; h <= 15; h++) begin
        drive(2'b01, h, v);
        if (v == 0 && h == 4) snk_ready_in = 1'b0;
        if (v == 0 && h == 12) snk_ready_in = 1'b1;
        if (v == 0 && h == 8) chk("ovf before", overflow_out, 0);
        if (v == 0 && h == 9) begin
          chk("ovf set", overflow_out, 1);
          chk("ovf hold valid", snk_valid_out, 1);
          chk("ovf hold pixel", {snk_hcount_out, snk_vcount_out, snk_data_out}, {10'd4, 9'd0, pix(1'b0, 4, 0)});
        end
      end
    idle(3);
    chk("ovf count", q.size() - base, 7);
    check_frame(base, 1'b0, 8, "ovf");
    chk("ovf sticky", overflow_out, 1);

    // src1 granted but silent: grant released after exactly 100 waiting cycles.
    do_reset(2'b11);
    frame(2'b01);
    idle(1);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (busy_out) cnt++;
      else break;
    end
    chk("timeout cycles", cnt, 100);
    base = q.size();
    frame(2'b01);
    idle(3);
    chk("after timeout count", q.size() - base, 8);
    check_frame(base, 1'b0, -1, "after timeout");
    chk("after timeout drops", drop_count_out, 0);

    // Enable src0 mid-frame: nothing until the next (0,0).
    do_reset(2'b00);
    base = q.size(); fs0 = fs_cnt;
    for (int v = 0; v <= 7; v++)
      for (int h = 0; h <= 15; h++) begin
        drive(2'b01, h, v);
        if (v == 3 && h == 6) src_enable_in = 2'b01;
      end
    idle(3);
    chk("midenable no pixels", q.size() - base, 0);
    chk("midenable no start", fs_cnt - fs0, 0);
    frame(2'b01);
    idle(3);
    chk("midenable count", q.size() - base, 8);
    check_frame(base, 1'b0, -1, "midenable");
    chk("midenable start once", fs_cnt - fs0, 1);
    chk("midenable drops", drop_count_out, 1);

    // Reset in the middle of a src1 frame (last served was src0) -> src0 first after release.
    do_reset(2'b11);
    frame(2'b01);
    idle(3);
    snk_ready_in = 1'b0;
    for (int v = 0; v <= 4; v++)
      for (int h = 0; h <= 15; h++) drive(2'b10, h, v);
    for (int h = 0; h <= 6; h++) drive(2'b10, h, 5);
    chk("pre-rst valid", snk_valid_out, 1);
    chk("pre-rst src", snk_src_out, 1);
    chk("pre-rst overflow", overflow_out, 1);
    chk("pre-rst busy", busy_out, 1);
    rst_in = 1'b0;
    #1;
    chk("mid rst outputs", {snk_valid_out, snk_data_out, snk_hcount_out, snk_vcount_out, snk_src_out,
        snk_last_out, frame_start_out, frame_end_out, busy_out, overflow_out, drop_count_out}, 64'd0);
    src0_valid_in = 1'b0;
    src1_valid_in = 1'b0;
    snk_ready_in  = 1'b1;
    step(); step();
    rst_in = 1'b1;
    idle(2);
    base = q.size();
    frame(2'b11);
    idle(3);
    chk("post-rst count", q.size() - base, 8);
    check_frame(base, 1'b0, -1, "post-rst");
    chk("post-rst drops", drop_count_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
